pop_count_rr_sched: RTL and testbench
=====================================

// Module: pop_count_rr_sched
// PURPOSE
//  Round-robin scheduler sharing one 32-bit popcount datapath between NREQ requesters.
//  - Each requester offers a 32-bit word on a valid/ready port.
//  - At most one word per cycle is granted and its popcount (0..32) is computed.
//  - The result goes to a single registered response port, tagged with the requester index.
//  - Sits between the requesting client blocks and the combinational SWAR popcount core.
// PARAMETERS
//  NREQ   4   number of requesters, 2..16
//  IDW    2   width of rsp_id; must equal clog2(NREQ), minimum 1
//  CNTW   16  width of the accepted-job statistics counter
// PORTS
//  clk        in   1         clock, all logic on rising edge
//  rst        in   1         synchronous reset, active-high
//  req_valid  in   NREQ      requester i has a word pending
//  req_data   in   NREQ*32   word of requester i on bits [32*i+31:32*i]
//  req_ready  out  NREQ      one-hot/zero grant; transfer when req_valid[i]&req_ready[i]
//  rsp_valid  out  1         response register holds a result
//  rsp_ready  in   1         consumer accepts result when rsp_valid&rsp_ready
//  rsp_id     out  IDW       index of requester that produced the result
//  rsp_count  out  6         popcount of that requester's word, 0..32
//  job_cnt    out  CNTW      total accepted requests, wraps modulo 2^CNTW
// BEHAVIOUR
//  Reset
//  - While rst=1 at a clock edge: rsp_valid=0, rsp_id=0, rsp_count=0, job_cnt=0, rr_ptr=0.
//  - req_ready is combinational and is 0 while rst=1.
//  - Reset mid-operation drops any held result. A word granted in the reset cycle is not transferred.
//  Slot free
//  - slot_free = !rsp_valid | rsp_ready. Back-to-back throughput is one result per cycle.
//  Arbitration
//  - Combinational. If slot_free, grant the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
//  - req_ready[i] = 1 only for the granted i. It depends on req_valid and rsp_ready; there is no req_valid -> req_ready loop inside the block.
//  - No valid request, or !slot_free: req_ready = 0.
//  - After a grant to i: rr_ptr <= (i+1) mod NREQ. Without a grant rr_ptr holds.
//  - Starvation bound: a continuously valid requester is granted within NREQ granting cycles.
//  Datapath
//  - The popcount of the granted word is computed combinationally: pairwise 1/2/4/8/16-bit field adds, 32-bit internal, low 6 bits kept.
//  - Result is registered on the grant edge. Latency is 1 cycle: accepted at edge N, visible on rsp_* after edge N.
//  Response register
//  - Grant: rsp_valid<=1, rsp_id<=i, rsp_count<=popcount.
//  - Drain (rsp_valid&rsp_ready) with no grant: rsp_valid<=0. rsp_id and rsp_count hold their stale values.
//  - Drain and grant in the same cycle: the new result replaces the old one. No bubble, no loss.
//  - rsp_valid=1 & rsp_ready=0: rsp_* stable and no grant issued (full stall).
//  Statistics
//  - job_cnt increments by 1 per grant, wrapping 2^CNTW-1 -> 0.
//  Boundaries
//  - All-zero word -> 0. All-ones word -> 32 (6'b100000).
//  - req_valid may deassert without a handshake; the arbiter simply re-evaluates.
// TESTING
//  1 After reset, req_valid=0 -> rsp_valid=0, job_cnt=0, req_ready=0000 for every cycle.
//  2 Req0 data=0xFFFFFFFF, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_count=32, job_cnt=1.
//  3 All 4 valid (0x0,0x1,0x80000001,0x5555AAAA), rsp_ready=1 -> ids 0,1,2,3 on consecutive cycles, counts 0,1,2,16.
//  4 Stall: rsp_ready=0 with result held -> rsp_* stable and req_ready=0 for 5 cycles.
//    Then rsp_ready=1 -> drain and the next grant happen in the same cycle.
//  5 Req1 and req3 always valid, rr_ptr=2 -> grant order 3,1,3,1. Neither waits more than NREQ grants.
//  6 rst=1 while rsp_valid=1 -> next cycle rsp_valid=0, job_cnt=0.
//    Also preload job_cnt=0xFFFF, one grant -> job_cnt=0x0000.

Source files
------------

// File: rtl/pop_count_rr_sched.sv
// ---------------------------------------------------------------------------
// pop_count_rr_sched
//
// Round-robin scheduler that shares one 32-bit popcount datapath between
// NREQ requesters. At most one word is granted per cycle. Its popcount is
// registered into a single response slot, tagged with the requester index.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous reset, active-high
//   req_valid  : per-requester "word pending" flags
//   req_data   : requester i's word on bits [32*i+31:32*i]
//   req_ready  : one-hot (or zero) grant, combinational
//   rsp_valid  : response register holds a result
//   rsp_ready  : consumer accepts the result when rsp_valid & rsp_ready
//   rsp_id     : index of the requester that produced the result
//   rsp_count  : popcount of that requester's word, 0..32
//   job_cnt    : running count of accepted requests, wraps
// ---------------------------------------------------------------------------
module pop_count_rr_sched #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int CNTW = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*32-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [IDW-1:0]     rsp_id,
   output logic [5:0]         rsp_count,
   output logic [CNTW-1:0]    job_cnt
);

   logic [IDW-1:0] rr_ptr;
   logic           slot_free;
   logic           grant_any;
   logic [IDW-1:0] grant_idx;
   logic [IDW-1:0] ptr_next;
   logic [31:0]    granted_word;
   logic [31:0]    s1, s2, s3, s4;
   logic [5:0]     pop;

   // The slot can take a new result when empty or being drained this cycle.
   assign slot_free = !rsp_valid || rsp_ready;

   // Round-robin search starting at rr_ptr. The candidate index is wrapped
   // by subtraction so that non-power-of-two NREQ works too. Grants are
   // suppressed during reset so nothing is transferred on a reset edge.
   always_comb begin
      int unsigned cand;
      grant_any    = 1'b0;
      grant_idx    = '0;
      req_ready    = '0;
      granted_word = '0;
      cand         = 0;
      if (!rst && slot_free) begin
         for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!grant_any && req_valid[cand]) begin
               grant_any       = 1'b1;
               grant_idx       = IDW'(cand);
               req_ready[cand] = 1'b1;
               granted_word    = req_data[cand*32 +: 32];
            end
         end
      end
   end

   // SWAR popcount: each stage adds neighbouring fields of doubling width.
   // Only the low 6 bits of the final sum are meaningful (max 32).
   always_comb begin
      s1  = (granted_word & 32'h5555_5555) + ((granted_word >> 1) & 32'h5555_5555);
      s2  = (s1 & 32'h3333_3333) + ((s1 >> 2) & 32'h3333_3333);
      s3  = (s2 & 32'h0F0F_0F0F) + ((s2 >> 4) & 32'h0F0F_0F0F);
      s4  = (s3 & 32'h00FF_00FF) + ((s3 >> 8) & 32'h00FF_00FF);
      pop = 6'((s4 & 32'h0000_FFFF) + ((s4 >> 16) & 32'h0000_FFFF));
   end

   // Pointer moves just past the winner so it becomes lowest priority.
   always_comb begin
      if (grant_idx == IDW'(NREQ - 1)) ptr_next = '0;
      else                             ptr_next = grant_idx + 1'b1;
   end

   // Response slot, pointer and statistics. A grant always overwrites the
   // slot (it is only granted when free or draining), so a drain and a grant
   // in the same cycle give back-to-back results with no bubble. A plain
   // drain only clears valid; id and count keep their stale values.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_count <= '0;
         job_cnt   <= '0;
         rr_ptr    <= '0;
      end else if (grant_any) begin
         rsp_valid <= 1'b1;
         rsp_id    <= grant_idx;
         rsp_count <= pop;
         job_cnt   <= job_cnt + 1'b1;
         rr_ptr    <= ptr_next;
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pop_count_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_pop_count_rr_sched
//
// Self-checking bench for pop_count_rr_sched (NREQ=4). A reference model
// runs on the falling edge: it checks outputs against the expected state,
// predicts the grant, and pushes expected {id, count} onto a scoreboard
// queue that is popped when the result is drained.
// ---------------------------------------------------------------------------
module tb_pop_count_rr_sched;

   logic         clk;
   logic         rst;
   logic [3:0]   req_valid;
   logic [127:0] req_data;
   logic [3:0]   req_ready;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [1:0]   rsp_id;
   logic [5:0]   rsp_count;
   logic [15:0]  job_cnt;

   typedef struct {
      int id;
      int cnt;
   } exp_t;

   exp_t        sb[$];
   int          compared;
   int          mismatched;
   bit          live;
   bit          m_valid;
   int          m_ptr;
   logic [15:0] m_job;

   pop_count_rr_sched #(.NREQ(4), .IDW(2), .CNTW(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_count (rsp_count),
      .job_cnt   (job_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts one comparison and reports it if the values differ.
   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drives one cycle of inputs and returns 1 time unit after the edge.
   task automatic applyStimulus(input logic [3:0] v, input logic rr,
                                input logic [127:0] d);
      req_valid = v;
      rsp_ready = rr;
      req_data  = d;
      @(posedge clk);
      #1;
   endtask

   // Reference model: check current outputs, then predict the next edge.
   always @(negedge clk) begin
      int   g;
      int   c;
      logic [3:0] exp_ready;
      exp_t e;
      if (live) begin
         checkOutput("rsp_valid", rsp_valid, m_valid);
         checkOutput("job_cnt", job_cnt, m_job);
         if (m_valid) begin
            if (sb.size() == 0) begin
               checkOutput("sb_empty", 1, 0);
            end else begin
               checkOutput("rsp_id", rsp_id, sb[0].id);
               checkOutput("rsp_count", rsp_count, sb[0].cnt);
               if (rsp_ready) void'(sb.pop_front());
            end
         end
      end
      g = -1;
      if (!rst && (!m_valid || rsp_ready)) begin
         for (int k = 0; k < 4; k++) begin
            c = (m_ptr + k) % 4;
            if (g < 0 && req_valid[c]) g = c;
         end
      end
      exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      if (live || rst) checkOutput("req_ready", req_ready, exp_ready);
      if (rst) begin
         m_valid = 1'b0;
         m_ptr   = 0;
         m_job   = '0;
         sb.delete();
         live    = 1'b1;
      end else if (live) begin
         if (g >= 0) begin
            e.id  = g;
            e.cnt = $countones(req_data[g*32 +: 32]);
            sb.push_back(e);
            m_valid = 1'b1;
            m_ptr   = (g + 1) % 4;
            m_job   = m_job + 16'd1;
         end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   initial begin
      logic [127:0] d3;
      int           cnt3[4];
      int           ord5[4];
      compared   = 0;
      mismatched = 0;
      live       = 1'b0;
      m_valid    = 1'b0;
      m_ptr      = 0;
      m_job      = '0;
      rst        = 1'b1;
      req_valid  = '0;
      req_data   = '0;
      rsp_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Idle after reset
      checkOutput("rst_rsp_id", rsp_id, 0);
      checkOutput("rst_rsp_count", rsp_count, 0);
      repeat (4) applyStimulus(4'b0000, 1'b1, '0);

      // All-ones word from requester 0
      applyStimulus(4'b0001, 1'b1, {96'h0, 32'hFFFF_FFFF});
      checkOutput("t2_valid", rsp_valid, 1);
      checkOutput("t2_id", rsp_id, 0);
      checkOutput("t2_count", rsp_count, 32);
      checkOutput("t2_job", job_cnt, 1);
      applyStimulus(4'b0000, 1'b1, '0);

      // Move pointer back to 0 via requester 3, then all four in turn
      applyStimulus(4'b1000, 1'b1, '0);
      d3 = {32'h5555_AAAA, 32'h8000_0001, 32'h0000_0001, 32'h0000_0000};
      cnt3[0] = 0; cnt3[1] = 1; cnt3[2] = 2; cnt3[3] = 16;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(4'b1111 << k, 1'b1, d3);
         checkOutput("t3_id", rsp_id, k);
         checkOutput("t3_count", rsp_count, cnt3[k]);
      end

      // Full stall: result held, no grants
      for (int k = 0; k < 5; k++) begin
         applyStimulus(4'b1111, 1'b0, d3);
         checkOutput("t4_stall_id", rsp_id, 3);
         checkOutput("t4_stall_count", rsp_count, 16);
         checkOutput("t4_stall_ready", req_ready, 0);
      end
      applyStimulus(4'b1111, 1'b1, d3);
      checkOutput("t4_resume_valid", rsp_valid, 1);
      checkOutput("t4_resume_id", rsp_id, 0);
      checkOutput("t4_resume_count", rsp_count, 0);

      // Pointer to 2 via requester 1, then 1 and 3 compete
      applyStimulus(4'b0010, 1'b1, d3);
      ord5[0] = 3; ord5[1] = 1; ord5[2] = 3; ord5[3] = 1;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(4'b1010, 1'b1, d3);
         checkOutput("t5_order", rsp_id, ord5[k]);
      end

      // Reset while a result is held
      checkOutput("t6_pre_valid", rsp_valid, 1);
      rst = 1'b1;
      applyStimulus(4'b1111, 1'b1, d3);
      rst = 1'b0;
      checkOutput("t6_valid", rsp_valid, 0);
      checkOutput("t6_job", job_cnt, 0);
      checkOutput("t6_id", rsp_id, 0);

      // Statistics counter wrap
      for (int k = 0; k < 65535; k++) applyStimulus(4'b0001, 1'b1, d3);
      checkOutput("t6_job_max", job_cnt, 16'hFFFF);
      applyStimulus(4'b0001, 1'b1, d3);
      checkOutput("t6_job_wrap", job_cnt, 16'h0000);
      repeat (3) applyStimulus(4'b0000, 1'b1, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
